// File: rtl/hamming_pkg.sv
// Shared widths, codeword layout tables and elaboration-time helpers for the
// Hamming(21,16) streaming encoder.
package hamming_pkg;

    localparam int DATA_W = 16;
    localparam int CW_W   = 21;
    localparam int POS_W  = 5;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CW_W-1:0]   cw_t;
    typedef logic [POS_W-1:0]  pos_t;

    // Highest legal out_cw bit index for error injection.
    localparam pos_t CW_LAST_BIT = POS_W'(CW_W - 1);

    localparam logic [1:0] FIFO_FULL = 2'd2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    // Hamming position (1..21) of each data bit; entry i (5 bits) belongs to data[i].
    localparam logic [DATA_W*POS_W-1:0] DATA_POS_TBL = {
        5'd3,  5'd5,  5'd6,  5'd7,
        5'd9,  5'd10, 5'd11, 5'd12,
        5'd13, 5'd14, 5'd15, 5'd17,
        5'd18, 5'd19, 5'd20, 5'd21
    };

    function automatic bit is_parity_pos(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Data bit index that lands on Hamming position p (only meaningful for data positions).
    function automatic int data_index(input int p);
        pos_t entry;
        for (int i = 0; i < DATA_W; i++) begin
            entry = POS_W'(DATA_POS_TBL >> (POS_W * i));
            if (int'(entry) == p) begin
                return i;
            end
        end
        return 0;
    endfunction

    // Data positions covered by parity position k; bit (q-1) stands for position q.
    function automatic cw_t cover_mask(input int k);
        int m;
        m = 0;
        for (int q = 1; q <= CW_W; q++) begin
            if (((q & k) != 0) && !is_parity_pos(q)) begin
                m = m | (1 << (q - 1));
            end
        end
        return CW_W'(m);
    endfunction

endpackage

// File: rtl/hamming_enc_comb.sv
// Pure combinational Hamming(21,16) encoder: Hamming position p is driven onto
// cw[21-p], parity sits at the power-of-two positions with even parity.
module hamming_enc_comb
    import hamming_pkg::*;
(
    input  data_t data,
    output cw_t   cw
);

    // Both vectors are indexed by Hamming position so the tables read naturally.
    logic [CW_W:1] data_pos;
    logic [CW_W:1] ham_pos;

    for (genvar p = 1; p <= CW_W; p++) begin : g_pos
        if (is_parity_pos(p)) begin : g_par
            localparam cw_t COVER = cover_mask(p);
            assign data_pos[p] = 1'b0;
            assign ham_pos[p]  = ^(data_pos & COVER);
        end else begin : g_data
            localparam int IDX = data_index(p);
            assign data_pos[p] = data[IDX];
            assign ham_pos[p]  = data_pos[p];
        end
        assign cw[CW_W-p] = ham_pos[p];
    end

endmodule

// File: rtl/hamming_encoder_stream.sv
// Streaming Hamming(21,16) encoder with a 2-entry skid FIFO, one-shot bit-flip
// injection and a count of codewords delivered downstream.
module hamming_encoder_stream
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW_W-1:0]  out_cw,
    input  logic             inj_req,
    input  logic [POS_W-1:0] inj_pos,
    output logic             inj_armed,
    output logic [CNT_W-1:0] word_cnt
);

    cw_t        enc_cw;
    cw_t        flip_mask;
    cw_t        store_cw;
    cw_t        mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [1:0] count_next;
    logic [0:0] inj_state;
    logic [0:0] inj_state_next;
    logic       accept;
    logic       send;
    logic       inject_now;

    hamming_enc_comb u_enc (
        .data (in_data),
        .cw   (enc_cw)
    );

    assign accept    = in_valid & in_ready;
    assign send      = out_valid & out_ready;
    assign out_valid = (count != 2'd0);
    assign out_cw    = mem[rd_ptr];
    assign inj_armed = (inj_state == ST_ARMED);

    // A request in the same cycle as an accept applies to that very word.
    assign inject_now = inj_armed | inj_req;

    always_comb begin
        flip_mask = '0;
        if (inject_now && (inj_pos <= CW_LAST_BIT)) begin
            flip_mask[inj_pos] = 1'b1;
        end
    end

    assign store_cw = enc_cw ^ flip_mask;

    always_comb begin
        count_next = count;
        case ({accept, send})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        inj_state_next = inj_state;
        if (accept) begin
            inj_state_next = ST_IDLE;
        end else if (inj_req) begin
            inj_state_next = ST_ARMED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
        end else if (accept) begin
            mem[wr_ptr] <= store_cw;
            wr_ptr      <= ~wr_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
        end else if (send) begin
            rd_ptr <= ~rd_ptr;
        end
    end

    // in_ready is registered, so it is derived from the occupancy after this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            in_ready <= 1'b0;
        end else begin
            count    <= count_next;
            in_ready <= (count_next < FIFO_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_state <= ST_IDLE;
        end else begin
            inj_state <= inj_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (send) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Scoreboard bench for hamming_encoder_stream: accepted words are encoded by an
// arithmetic reference model and matched against codewords leaving the DUT.
module tb_hamming_encoder_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] out_cw;
    logic        inj_req;
    logic [4:0]  inj_pos;
    logic        inj_armed;
    logic [15:0] word_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [20:0] exp_q [$];
    int          sent_cnt = 0;
    bit          model_armed = 1'b0;
    bit          rel_edge = 1'b0;
    bit          stall_prev = 1'b0;
    logic [20:0] prev_cw = '0;
    int          cyc = 0;

    always #5 clk = ~clk;

    hamming_encoder_stream #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cw    (out_cw),
        .inj_req   (inj_req),
        .inj_pos   (inj_pos),
        .inj_armed (inj_armed),
        .word_cnt  (word_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Hamming positions 1..21 held in an int, data filling non-power-of-two slots MSB first.
    function automatic logic [20:0] refEncode(input logic [15:0] d, input bit flip, input int pos);
        int dv;
        int v;
        int di;
        int par;
        int code;
        dv = int'(d);
        v = 0;
        di = 15;
        code = 0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                v = v | (((dv >> di) & 1) << p);
                di--;
            end
        end
        for (int k = 1; k <= 16; k = k * 2) begin
            par = 0;
            for (int p = 1; p <= 21; p++) begin
                if ((p & k) != 0) par = par ^ ((v >> p) & 1);
            end
            v = v | (par << k);
        end
        for (int p = 1; p <= 21; p++) begin
            code = code | (((v >> p) & 1) << (21 - p));
        end
        if (flip && pos <= 20) code = code ^ (1 << pos);
        return 21'(code);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rel_edge <= 1'b0;
        else        rel_edge <= 1'b1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic monitorCycle();
        logic [20:0] e;
        if (!rst_n) begin
            checkOutput("rst_in_ready", 32'(in_ready), 32'(0));
            checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
            checkOutput("rst_out_cw", 32'(out_cw), 32'(0));
            checkOutput("rst_word_cnt", 32'(word_cnt), 32'(0));
            checkOutput("rst_inj_armed", 32'(inj_armed), 32'(0));
            exp_q.delete();
            sent_cnt = 0;
            model_armed = 1'b0;
            stall_prev = 1'b0;
            return;
        end
        checkOutput("in_ready", 32'(in_ready), 32'(rel_edge && (exp_q.size() < 2)));
        checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        checkOutput("inj_armed", 32'(inj_armed), 32'(model_armed));
        checkOutput("word_cnt", 32'(word_cnt), 32'(16'(sent_cnt)));
        if (stall_prev) checkOutput("cw_hold", 32'(out_cw), 32'(prev_cw));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_output", 32'(out_valid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_cw", 32'(out_cw), 32'(e));
            end
            sent_cnt++;
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(refEncode(in_data, model_armed || inj_req, int'(inj_pos)));
            model_armed = 1'b0;
        end else if (inj_req) begin
            model_armed = 1'b1;
        end
        stall_prev = out_valid && !out_ready;
        prev_cw = out_cw;
    endtask

    always @(negedge clk) monitorCycle();

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        in_valid = 1'b0;
        inj_req = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic req, input logic [4:0] pos);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data = d;
        inj_req = req;
        inj_pos = pos;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited >= 64) begin
                checkOutput("accept_timeout", 32'(in_ready), 32'(1));
                setIdle();
                return;
            end
        end
        @(posedge clk);
        #1;
        inj_req = 1'b0;
    endtask

    task automatic requestInjection(input logic [4:0] pos);
        inj_req = 1'b1;
        inj_pos = pos;
        waitCycles(1);
        inj_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int start_c;
        int end_c;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        inj_req = 1'b0;
        inj_pos = '0;
        waitCycles(3);
        rst_n = 1'b1;
        checkOutput("in_ready_at_release", 32'(in_ready), 32'(0));
        waitCycles(1);
        checkOutput("in_ready_first_cycle", 32'(in_ready), 32'(1));
        out_ready = 1'b1;

        $display("[TB] directed codewords");
        applyStimulus(16'h0000, 1'b0, 5'd0);
        checkOutput("lat_valid_0000", 32'(out_valid), 32'(1));
        checkOutput("cw_0000", 32'(out_cw), 32'h000000);
        setIdle();
        waitCycles(1);
        applyStimulus(16'hFFFF, 1'b0, 5'd0);
        checkOutput("cw_ffff", 32'(out_cw), 32'h0FFFFF);
        setIdle();
        waitCycles(1);
        applyStimulus(16'h8000, 1'b0, 5'd0);
        checkOutput("cw_8000", 32'(out_cw), 32'h1C0000);
        setIdle();
        waitCycles(1);

        $display("[TB] error injection");
        requestInjection(5'd5);
        checkOutput("armed_after_req", 32'(inj_armed), 32'(1));
        applyStimulus(16'h0000, 1'b0, 5'd5);
        checkOutput("cw_inj5", 32'(out_cw), 32'h000020);
        checkOutput("disarmed_after_accept", 32'(inj_armed), 32'(0));
        setIdle();
        waitCycles(1);
        applyStimulus(16'h0000, 1'b0, 5'd5);
        checkOutput("cw_clean_after_inj", 32'(out_cw), 32'h000000);
        setIdle();
        waitCycles(1);
        requestInjection(5'd3);
        requestInjection(5'd9);
        applyStimulus(16'h1234, 1'b0, 5'd9);
        setIdle();
        waitCycles(1);
        applyStimulus(16'hABCD, 1'b1, 5'd12);
        setIdle();
        waitCycles(1);
        requestInjection(5'd25);
        applyStimulus(16'h5A5A, 1'b0, 5'd25);
        setIdle();
        waitCycles(2);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(16'hC001, 1'b0, 5'd0);
        applyStimulus(16'hC002, 1'b0, 5'd0);
        in_data = 16'hC003;
        waitCycles(3);
        checkOutput("in_ready_full", 32'(in_ready), 32'(0));
        out_ready = 1'b1;
        applyStimulus(16'hC003, 1'b0, 5'd0);
        setIdle();
        drain();

        $display("[TB] random backpressure");
        fork
            begin
                repeat (400) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join_none
        for (int i = 0; i < 150; i++) begin
            applyStimulus(16'($urandom), ($urandom_range(0, 9) == 0), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) begin
                setIdle();
                waitCycles(1);
            end
        end
        setIdle();
        wait fork;
        out_ready = 1'b1;
        drain();

        $display("[TB] back-to-back random stream");
        rst_n = 1'b0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(1);
        out_ready = 1'b1;
        start_c = cyc;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(16'($urandom), ($urandom_range(0, 19) == 0), 5'($urandom_range(0, 31)));
        end
        end_c = cyc;
        setIdle();
        checkOutput("throughput_cycles", 32'(end_c - start_c), 32'd1000);
        drain();
        checkOutput("word_cnt_1000", 32'(word_cnt), 32'd1000);

        $display("[TB] reset with buffered words");
        out_ready = 1'b0;
        applyStimulus(16'h1111, 1'b0, 5'd0);
        applyStimulus(16'h2222, 1'b0, 5'd0);
        setIdle();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'(0));
        checkOutput("midrst_word_cnt", 32'(word_cnt), 32'(0));
        checkOutput("midrst_in_ready", 32'(in_ready), 32'(0));
        waitCycles(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        waitCycles(1);
        checkOutput("in_ready_after_rst", 32'(in_ready), 32'(1));
        checkOutput("out_valid_after_rst", 32'(out_valid), 32'(0));
        applyStimulus(16'h0F0F, 1'b0, 5'd0);
        setIdle();
        drain();
        checkOutput("word_cnt_after_rst", 32'(word_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
